// File: rtl/lcv_mul_acc_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : lcv_mul_acc_pipe
//  Brief    : Pipelined signed multiply-accumulate, valid/ready stream.
//             Per beat: acc = a*b + c (load) or acc + a*b + c (accumulate).
//             Emits the accumulator on the beat flagged last, with an
//             optional saturating mode and a sticky overflow flag.
//  Revision : 1.0 - initial release
// ============================================================================
module lcv_mul_acc_pipe #(
    parameter int A_WIDTH    = 16,
    parameter int B_WIDTH    = 16,
    parameter int ACC_WIDTH  = 48,
    parameter int MUL_STAGES = 2,
    parameter int SATURATE   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_WIDTH-1:0]   in_a,
    input  logic [B_WIDTH-1:0]   in_b,
    input  logic [ACC_WIDTH-1:0] in_c,
    input  logic                 in_load,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_acc,
    output logic                 out_ovf
);

    localparam int c_PROD_W = A_WIDTH + B_WIDTH;
    // Two guard bits: a*b+c needs one, adding the accumulator needs one more.
    localparam int c_SUM_W  = ACC_WIDTH + 2;
    localparam logic [ACC_WIDTH-1:0] c_ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] c_ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic                      w_adv;
    logic signed [c_PROD_W-1:0] w_prod;
    logic [c_SUM_W-1:0]        w_p_in;

    logic [c_SUM_W-1:0]        r_p   [MUL_STAGES];
    logic                      r_ld  [MUL_STAGES];
    logic                      r_lst [MUL_STAGES];
    logic                      r_vld [MUL_STAGES];

    logic [ACC_WIDTH-1:0]      r_acc;
    logic                      r_ovf;
    logic [ACC_WIDTH-1:0]      r_out_acc;
    logic                      r_out_ovf;
    logic                      r_out_valid;

    logic [c_SUM_W-1:0]        w_base;
    logic [c_SUM_W-1:0]        w_sum;
    logic                      w_pos_ovf;
    logic                      w_neg_ovf;
    logic [ACC_WIDTH-1:0]      w_acc_next;
    logic                      w_ovf_next;
    logic                      w_tail_vld;
    logic                      w_tail_ld;
    logic                      w_tail_lst;

    // The whole pipe advances together unless a held result is blocking it.
    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = w_adv;

    assign w_prod = $signed(in_a) * $signed(in_b);
    assign w_p_in = {{(c_SUM_W-c_PROD_W){w_prod[c_PROD_W-1]}}, w_prod}
                  + {{2{in_c[ACC_WIDTH-1]}}, in_c};

    assign w_tail_vld = r_vld[MUL_STAGES-1];
    assign w_tail_ld  = r_ld[MUL_STAGES-1];
    assign w_tail_lst = r_lst[MUL_STAGES-1];

    assign w_base = w_tail_ld ? '0 : {{2{r_acc[ACC_WIDTH-1]}}, r_acc};
    assign w_sum  = w_base + r_p[MUL_STAGES-1];

    // Sum is out of range when the guard bits disagree with the result sign bit.
    assign w_pos_ovf = !w_sum[c_SUM_W-1] && (w_sum[c_SUM_W-2:ACC_WIDTH-1] != 2'b00);
    assign w_neg_ovf =  w_sum[c_SUM_W-1] && (w_sum[c_SUM_W-2:ACC_WIDTH-1] != 2'b11);

    assign w_ovf_next = (w_tail_ld ? 1'b0 : r_ovf) | w_pos_ovf | w_neg_ovf;

    // Next accumulator value: clamp when saturating, otherwise plain wrap.
    always_comb begin
        w_acc_next = w_sum[ACC_WIDTH-1:0];
        if (SATURATE != 0) begin
            if (w_pos_ovf) begin
                w_acc_next = c_ACC_MAX;
            end else if (w_neg_ovf) begin
                w_acc_next = c_ACC_MIN;
            end
        end
    end

    // Multiply pipeline, accumulator and output register, all gated by w_adv.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                r_p[i]   <= '0;
                r_ld[i]  <= 1'b0;
                r_lst[i] <= 1'b0;
                r_vld[i] <= 1'b0;
            end
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_out_acc   <= '0;
            r_out_ovf   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_adv) begin
            r_vld[0] <= in_valid;
            if (in_valid) begin
                r_p[0]   <= w_p_in;
                r_ld[0]  <= in_load;
                r_lst[0] <= in_last;
            end
            for (int i = 1; i < MUL_STAGES; i++) begin
                r_p[i]   <= r_p[i-1];
                r_ld[i]  <= r_ld[i-1];
                r_lst[i] <= r_lst[i-1];
                r_vld[i] <= r_vld[i-1];
            end
            if (w_tail_vld) begin
                r_acc <= w_acc_next;
                r_ovf <= w_ovf_next;
            end
            if (w_tail_vld && w_tail_lst) begin
                r_out_acc   <= w_acc_next;
                r_out_ovf   <= w_ovf_next;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_acc   = r_out_acc;
    assign out_ovf   = r_out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_lcv_mul_acc_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lcv_mul_acc_pipe
//  Brief    : Scoreboard bench for lcv_mul_acc_pipe. Two 32-bit instances
//             (wrapping and saturating) share the stimulus; expected packet
//             results are queued at accept time and checked on output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lcv_mul_acc_pipe;

    localparam int c_MS = 2;
    localparam longint c_MAX = 64'sd2147483647;
    localparam longint c_MIN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic [31:0] in_c = '0;
    logic        in_load = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;

    logic        w_in_ready, s_in_ready;
    logic        w_out_valid, s_out_valid;
    logic [31:0] w_out_acc, s_out_acc;
    logic        w_out_ovf, s_out_ovf;

    int n_chk  = 0;
    int n_fail = 0;

    logic [32:0] q_w[$];
    logic [32:0] q_s[$];
    logic [31:0] m_acc_w = '0, m_acc_s = '0;
    logic        m_ovf_w = 1'b0, m_ovf_s = 1'b0;

    always #5 clk = ~clk;

    lcv_mul_acc_pipe #(.A_WIDTH(16), .B_WIDTH(16), .ACC_WIDTH(32),
                       .MUL_STAGES(c_MS), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_load(in_load), .in_last(in_last),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_acc(w_out_acc), .out_ovf(w_out_ovf));

    lcv_mul_acc_pipe #(.A_WIDTH(16), .B_WIDTH(16), .ACC_WIDTH(32),
                       .MUL_STAGES(c_MS), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_load(in_load), .in_last(in_last),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_acc(s_out_acc), .out_ovf(s_out_ovf));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model step for one accepted beat.
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic [31:0] c,
                         input logic ld, input logic lst);
        longint p, s;
        logic   ov;
        p = longint'($signed(a)) * longint'($signed(b)) + longint'($signed(c));
        // wrapping instance
        s  = (ld ? 64'sd0 : longint'($signed(m_acc_w))) + p;
        ov = (s > c_MAX) || (s < c_MIN);
        m_acc_w = s[31:0];
        m_ovf_w = (ld ? 1'b0 : m_ovf_w) | ov;
        // saturating instance
        s  = (ld ? 64'sd0 : longint'($signed(m_acc_s))) + p;
        ov = (s > c_MAX) || (s < c_MIN);
        m_acc_s = (s > c_MAX) ? 32'h7FFF_FFFF : (s < c_MIN) ? 32'h8000_0000 : s[31:0];
        m_ovf_s = (ld ? 1'b0 : m_ovf_s) | ov;
        if (lst) begin
            q_w.push_back({m_ovf_w, m_acc_w});
            q_s.push_back({m_ovf_s, m_acc_s});
        end
    endtask

    // Drive one beat, wait (bounded) for acceptance, update the model.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [31:0] c,
                        input logic ld, input logic lst);
        int cnt;
        in_a = a; in_b = b; in_c = c; in_load = ld; in_last = lst; in_valid = 1'b1;
        cnt = 0;
        while (!w_in_ready && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (!w_in_ready) begin
            chk("accept_timeout", 64'(w_in_ready), 64'd1);
        end else begin
            @(posedge clk); #1;
            model(a, b, c, ld, lst);
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        q_w.delete(); q_s.delete();
        m_acc_w = '0; m_acc_s = '0; m_ovf_w = 1'b0; m_ovf_s = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Output monitor: pops on transfer, checks held value while stalled.
    always @(negedge clk) begin
        if (!rst) begin
            if (w_out_valid !== s_out_valid)
                chk("valid_agree", 64'(s_out_valid), 64'(w_out_valid));
            if (w_out_valid) begin
                if (q_w.size() == 0) begin
                    chk("unexpected_out", 64'(w_out_valid), 64'd0);
                end else if (out_ready) begin
                    logic [32:0] ew, es;
                    ew = q_w.pop_front();
                    es = q_s.pop_front();
                    chk("acc_wrap", 64'(w_out_acc), 64'(ew[31:0]));
                    chk("ovf_wrap", 64'(w_out_ovf), 64'(ew[32]));
                    chk("acc_sat",  64'(s_out_acc), 64'(es[31:0]));
                    chk("ovf_sat",  64'(s_out_ovf), 64'(es[32]));
                end else begin
                    chk("hold_acc", 64'(w_out_acc), 64'(q_w[0][31:0]));
                    chk("hold_rdy", 64'(w_in_ready), 64'd0);
                end
            end
        end
    end

    initial begin
        int cnt;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        chk("rst_valid", 64'(w_out_valid), 64'd0);
        chk("rst_acc",   64'(w_out_acc),   64'd0);
        chk("rst_ovf",   64'(w_out_ovf),   64'd0);
        chk("rst_ready", 64'(w_in_ready),  64'd1);

        // single beat with latency check: 3*-4+10 = -2
        send(16'd3, -16'sd4, 32'd10, 1'b1, 1'b1);
        for (int k = 1; k <= c_MS; k++) begin
            @(posedge clk); #1;
            chk("latency", 64'(w_out_valid), (k == c_MS) ? 64'd1 : 64'd0);
        end
        idle(3);

        // 4-beat packet: 1*2+2*2+3*2+4*2 = 20
        for (int i = 1; i <= 4; i++)
            send(16'(i), 16'd2, 32'd0, i == 1, i == 4);
        idle(6);

        // back-to-back single-beat packets, independent results
        send(16'd7, 16'd5, 32'd1, 1'b1, 1'b1);
        send(-16'sd2, 16'd9, 32'd4, 1'b1, 1'b1);
        repeat (c_MS - 1) @(posedge clk);
        #1 chk("b2b_first", 64'(w_out_valid), 64'd1);
        @(posedge clk); #1 chk("b2b_second", 64'(w_out_valid), 64'd1);
        @(posedge clk); #1 chk("b2b_gap", 64'(w_out_valid), 64'd0);
        idle(2);

        // backpressure: two packets in while downstream holds off
        out_ready = 1'b0;
        send(16'd100, 16'd3, 32'd0, 1'b1, 1'b1);
        send(16'd11, 16'd11, 32'd0, 1'b1, 1'b1);
        cnt = 0;
        while (!w_out_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("bp_valid", 64'(w_out_valid), 64'd1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_ready", 64'(w_in_ready), 64'd0);
        end
        out_ready = 1'b1;
        idle(6);

        // positive overflow: wrap -> 0x800000EF, sat -> 0x7FFFFFFF, both ovf
        send(16'd0, 16'd0, 32'h7FFF_FFF0, 1'b1, 1'b0);
        send(-16'sd1, 16'd1, 32'h0000_0100, 1'b0, 1'b1);
        // a fresh load clears ovf; then a continuation packet
        send(16'd0, 16'd0, 32'd5, 1'b1, 1'b1);
        send(16'd1, 16'd1, 32'd0, 1'b0, 1'b1);
        // negative overflow
        send(16'd0, 16'd0, 32'h8000_0000, 1'b1, 1'b0);
        send(-16'sd1, 16'd1, 32'd0, 1'b0, 1'b1);
        idle(6);

        // reset mid-packet, then a load=0 packet accumulates from zero
        send(16'd50, 16'd50, 32'd5, 1'b1, 1'b0);
        send(16'd10, 16'd10, 32'd0, 1'b0, 1'b1);
        do_reset();
        chk("midrst_valid", 64'(w_out_valid), 64'd0);
        idle(c_MS + 2);
        chk("midrst_quiet", 64'(w_out_valid), 64'd0);
        send(16'd2, 16'd3, 32'd1, 1'b0, 1'b1);
        idle(6);

        chk("queue_drained", 64'(q_w.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
